// File: rtl/rtype_encoder.sv
// rtype_encoder: builds MIPS32 R-type instruction words from an operation
// selector plus register fields and queues them in a small FIFO. Words leave
// on a valid/ready port, tagged with a running word address that starts at
// BASE_ADDR and advances by 4 on every pop.
//
// Optional feature: define RTYPE_ENC_JUMP_EN to make jr (14) and jalr (15)
// legal. Without it, both are rejected like any other illegal selector.

module rtype_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        err_illegal,
    output logic [7:0]  err_count
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic [31:0]   addr_q,   addr_d;
    logic          err_q,    err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          accept;
    logic          legal;
    logic          push;
    logic          pop;
    logic [5:0]    funct;
    logic [4:0]    rs_f, rt_f, rd_f, sh_f;
    logic [31:0]   word;

    // Ready depends only on registered occupancy, never on instr_ready.
    assign op_ready    = (count_q != FULL_CNT);
    assign instr_valid = (count_q != '0);
    assign accept      = op_valid && op_ready;
    assign push        = accept && legal;
    assign pop         = instr_valid && instr_ready;

    // Operation decode: funct lookup plus per-op field forcing.
    always_comb begin
        funct = 6'h00;
        legal = 1'b1;
        rs_f  = rs;
        rt_f  = rt;
        rd_f  = rd;
        sh_f  = 5'd0;
        case (op)
            5'd0:  funct = 6'h21;
            5'd1:  funct = 6'h23;
            5'd2:  funct = 6'h2A;
            5'd3:  funct = 6'h2B;
            5'd4:  funct = 6'h24;
            5'd5:  funct = 6'h25;
            5'd6:  funct = 6'h26;
            5'd7:  funct = 6'h27;
            5'd8: begin
                funct = 6'h00;
                rs_f  = 5'd0;
                sh_f  = shamt;
            end
            5'd9: begin
                funct = 6'h02;
                rs_f  = 5'd0;
                sh_f  = shamt;
            end
            5'd10: begin
                funct = 6'h03;
                rs_f  = 5'd0;
                sh_f  = shamt;
            end
            5'd11: funct = 6'h04;
            5'd12: funct = 6'h06;
            5'd13: funct = 6'h07;
`ifdef RTYPE_ENC_JUMP_EN
            5'd14: begin
                funct = 6'h08;
                rt_f  = 5'd0;
                rd_f  = 5'd0;
            end
            5'd15: begin
                funct = 6'h09;
                rt_f  = 5'd0;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    assign word = {6'b000000, rs_f, rt_f, rd_f, sh_f, funct};

    // Next-state for pointers, occupancy, address tag and error tracking.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = accept && !legal;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            addr_d   = addr_q + 32'd4;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (accept && !legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control state register; reset discards any queued words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; contents are masked by occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    // Head word comes straight from storage; forced to zero while empty.
    assign instr       = instr_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
    assign instr_addr  = addr_q;
    assign err_illegal = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_rtype_encoder.sv
// Directed bench for rtype_encoder with a scoreboard queue of {addr, word}.
module tb_rtype_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op, rs, rt, rd, shamt;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        err_illegal;
    logic [7:0]  err_count;

    int compared   = 0;
    int mismatched = 0;
    int words_out  = 0;
    int pulses     = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [7:0]  exp_err;

    rtype_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_addr(instr_addr), .err_illegal(err_illegal), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [4:0] o, a, b, c, s);
        logic [5:0] f;
        logic       ok;
        logic [4:0] ra, rb, rc, sh;
        ok = 1'b1; f = 6'h00; ra = a; rb = b; rc = c; sh = 5'd0;
        case (o)
            5'd0:  f = 6'h21;
            5'd1:  f = 6'h23;
            5'd2:  f = 6'h2A;
            5'd3:  f = 6'h2B;
            5'd4:  f = 6'h24;
            5'd5:  f = 6'h25;
            5'd6:  f = 6'h26;
            5'd7:  f = 6'h27;
            5'd8:  begin f = 6'h00; ra = 5'd0; sh = s; end
            5'd9:  begin f = 6'h02; ra = 5'd0; sh = s; end
            5'd10: begin f = 6'h03; ra = 5'd0; sh = s; end
            5'd11: f = 6'h04;
            5'd12: f = 6'h06;
            5'd13: f = 6'h07;
`ifdef RTYPE_ENC_JUMP_EN
            5'd14: begin f = 6'h08; rb = 5'd0; rc = 5'd0; end
            5'd15: begin f = 6'h09; rb = 5'd0; end
`endif
            default: ok = 1'b0;
        endcase
        return {ok, 6'b000000, ra, rb, rc, sh, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: compare every popped word against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            words_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", {instr_addr, instr}, 64'h0);
            end else begin
                check("scoreboard", {instr_addr, instr}, exp_q.pop_front());
            end
        end
        if (rst_n === 1'b1 && err_illegal === 1'b1) pulses++;
    end

    task automatic do_op(input logic [4:0] o, a, b, c, s);
        logic [32:0] m;
        bit ok;
        ok = 0;
        op_valid = 1'b1; op = o; rs = a; rt = b; rd = c; shamt = s;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (op_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            op_valid = 1'b0;
            check("op_accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            op_valid = 1'b0;
            m = model(o, a, b, c, s);
            if (m[32]) begin
                exp_q.push_back({exp_addr, m[31:0]});
                exp_addr = exp_addr + 32'd4;
            end else if (exp_err != 8'hFF) begin
                exp_err = exp_err + 8'd1;
            end
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && instr_valid === 1'b0) begin done = 1; break; end
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    int w0, p0;

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
        shamt = '0; instr_ready = 1'b1;
        exp_addr = BASE; exp_err = 8'd0;
        #12;
        check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_instr_addr", {32'd0, instr_addr}, {32'd0, BASE});
        check("rst_op_ready", {63'd0, op_ready}, 64'd1);
        check("rst_err", {55'd0, err_count, err_illegal}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // addu: visible one cycle after acceptance
        do_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
        check("addu_valid", {63'd0, instr_valid}, 64'd1);
        check("addu_word", {32'd0, instr}, {32'd0, 32'h0022_1821});
        check("addu_addr", {32'd0, instr_addr}, {32'd0, BASE});
        wait_drain();

        // sll forces rs to 0; addu forces shamt to 0
        do_op(5'd8, 5'd7, 5'd5, 5'd4, 5'd2);
        check("sll_word", {32'd0, instr}, {32'd0, 32'h0005_2080});
        do_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd9);
        check("addu_shamt", {59'd0, instr[10:6]}, 64'd0);
        wait_drain();

        // jr / jalr
        p0 = pulses;
`ifdef RTYPE_ENC_JUMP_EN
        do_op(5'd14, 5'd31, 5'd3, 5'd3, 5'd0);
        check("jr_word", {32'd0, instr}, {32'd0, 32'h03E0_0008});
        wait_drain();
        do_op(5'd15, 5'd9, 5'd4, 5'd31, 5'd0);
        check("jalr_word", {32'd0, instr}, {32'd0, 32'h0120_F809});
        wait_drain();
`else
        do_op(5'd14, 5'd31, 5'd3, 5'd3, 5'd0);
        check("jr_err_pulse", {63'd0, err_illegal}, 64'd1);
        check("jr_err_count", {56'd0, err_count}, 64'd1);
        check("jr_no_word", {63'd0, instr_valid}, 64'd0);
        @(posedge clk); #1;
        check("jr_pulse_end", {63'd0, err_illegal}, 64'd0);
        check("jr_pulse_cnt", 64'(pulses - p0), 64'd1);
`endif

        // full FIFO with back-pressure
        instr_ready = 1'b0;
        do_op(5'd4, 5'd1, 5'd2, 5'd3, 5'd0);
        do_op(5'd5, 5'd4, 5'd5, 5'd6, 5'd0);
        do_op(5'd6, 5'd7, 5'd8, 5'd9, 5'd0);
        do_op(5'd7, 5'd10, 5'd11, 5'd12, 5'd0);
        check("full_op_ready", {63'd0, op_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_head_stable", {instr_addr, instr}, exp_q[0]);
        end
        check("full_still_blocked", {63'd0, op_ready}, 64'd0);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        check("pop_one_addr", {32'd0, instr_addr}, {32'd0, exp_q[0][63:32]});
        check("ready_release", {63'd0, op_ready}, 64'd1);
        check("pop_one_left", 64'(exp_q.size()), 64'd3);
        instr_ready = 1'b1;
        wait_drain();

        // illegal op interleaved in a back-to-back stream
        w0 = words_out; p0 = pulses;
        do_op(5'd0, 5'd2, 5'd3, 5'd4, 5'd0);
        do_op(5'd20, 5'd1, 5'd1, 5'd1, 5'd0);
        check("mix_err_pulse", {63'd0, err_illegal}, 64'd1);
        do_op(5'd1, 5'd5, 5'd6, 5'd7, 5'd0);
        wait_drain();
        check("mix_words", 64'(words_out - w0), 64'd2);
        check("mix_pulses", 64'(pulses - p0), 64'd1);
        check("mix_err_count", {56'd0, err_count}, {56'd0, exp_err});

        // saturation of the error counter
        w0 = words_out;
        for (int i = 0; i < 300; i++) begin
            do_op(5'(16 + (i % 16)), 5'd1, 5'd2, 5'd3, 5'd4);
        end
        @(posedge clk); #1;
        check("err_saturate", {56'd0, err_count}, 64'd255);
        check("err_sat_model", {56'd0, err_count}, {56'd0, exp_err});
        check("illegal_no_words", 64'(words_out - w0), 64'd0);

        // asynchronous reset with words queued
        instr_ready = 1'b0;
        do_op(5'd2, 5'd1, 5'd2, 5'd3, 5'd0);
        do_op(5'd3, 5'd4, 5'd5, 5'd6, 5'd0);
        do_op(5'd9, 5'd0, 5'd7, 5'd8, 5'd5);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, instr_valid}, 64'd0);
        check("arst_addr", {32'd0, instr_addr}, {32'd0, BASE});
        check("arst_instr", {32'd0, instr}, 64'd0);
        check("arst_ready_err", {55'd0, op_ready, err_count}, {55'd0, 1'b1, 8'd0});
        exp_q.delete();
        exp_addr = BASE; exp_err = 8'd0;
        @(negedge clk); rst_n = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        do_op(5'd13, 5'd3, 5'd2, 5'd1, 5'd0);
        check("post_rst_addr", {32'd0, instr_addr}, {32'd0, BASE});
        check("post_rst_word", {32'd0, instr}, {32'd0, 32'h0062_0807});
        wait_drain();
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rtype_encoder.md
# rtype_encoder

Instruction-word builder for the single-cycle MIPS32 core's R-type path. It accepts an abstract operation selector and register fields, and produces the 32-bit R-type instruction word, including the `funct` code that the ALU control decoder later consumes. Encoded words pass through a small FIFO and leave on a valid/ready port, tagged with a running word address. The block feeds instruction-memory loaders and self-checking program generators.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: address tagged on the first word after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request valid.
- `op_ready`  out  1  request can be accepted.
- `op`  in  5  operation selector (see Operation).
- `rs`, `rt`, `rd`  in  5 each  register fields.
- `shamt`  in  5  shift amount.
- `instr_valid`  out  1  FIFO head holds a word.
- `instr_ready`  in  1  consumer takes the head word.
- `instr`  out  32  encoded word at FIFO head.
- `instr_addr`  out  32  address of the current head word.
- `err_illegal`  out  1  one-cycle pulse for a rejected op.
- `err_count`  out  8  saturating count of rejected ops.

## Operation
- **Accept:** a request is accepted when `op_valid && op_ready`.
- **Ready:** `op_ready = !full`, where full means the FIFO holds `DEPTH` entries.
- **Op map** (`op` → `funct`):
  - 0 addu 6'h21, 1 subu 6'h23, 2 slt 6'h2A, 3 sltu 6'h2B
  - 4 and 6'h24, 5 or 6'h25, 6 xor 6'h26, 7 nor 6'h27
  - 8 sll 6'h00, 9 srl 6'h02, 10 sra 6'h03
  - 11 sllv 6'h04, 12 srlv 6'h06, 13 srav 6'h07
  - 14 jr 6'h08, 15 jalr 6'h09
  - 16–31 are illegal.
- **Word format:** {6'b0, rs, rt, rd, shamt, funct}. Opcode is always 0.
- **Field forcing:**
  - Ops 8–10: rs forced to 0; shamt taken from the input.
  - All other ops: shamt forced to 0.
  - jr: rt = rd = 0.
  - jalr: rt = 0; rd passed through.
- **Illegal op:**
  - The request is still consumed (handshake completes) and nothing is written to the FIFO.
  - `err_illegal` is high for exactly the cycle after acceptance.
  - `err_count` increments and saturates at 255.
- **FIFO:**
  - Circular buffer with `log2(DEPTH)`-bit read/write pointers and a `DEPTH+1`-range occupancy counter; pointers wrap modulo `DEPTH`.
- **Output handshake:**
  - On `instr_valid && instr_ready`, the head is popped and `instr_addr` increases by 4.
  - `instr_addr` wraps 32'hFFFF_FFFC → 0.
- **Stability:** `instr` and `instr_addr` hold stable while `instr_valid && !instr_ready`.
- **Simultaneous push and pop:** when not full, occupancy is unchanged and both pointers advance. When full, no push is possible because `op_ready = 0`.
- **Reset (asynchronous, mid-operation included):**
  - The FIFO empties and pointers are cleared.
  - `instr_valid` = 0, `instr` = 0, `instr_addr` = `BASE_ADDR`.
  - `err_illegal` = 0, `err_count` = 0, `op_ready` = 1.
  - In-flight words are discarded.

## Timing
- **Latency:** an op accepted on edge N yields `instr_valid = 1` in the cycle after edge N (1 cycle) when the FIFO was empty.
- **Throughput:** one op per cycle in and one word per cycle out, sustained while `instr_ready = 1`.
- **Ready path:** `op_ready` depends only on registered occupancy. There is no combinational path from `instr_ready` to `op_ready`.
- **Ready release:** after a pop from full on edge N, `op_ready` rises in the cycle after edge N.
- **Head output:** `instr` is read from the registered head entry, so there is no combinational path from the `op` inputs to `instr`.

## Configuration
- **`RTYPE_ENC_JUMP_EN` defined:**
  - ops 14 (jr) and 15 (jalr) are legal and encoded as above.
- **`RTYPE_ENC_JUMP_EN` undefined:**
  - ops 14 and 15 are treated as illegal: `err_illegal` pulses, `err_count` increments, and no word is emitted.
  - All other behaviour is identical.

## Test plan
- **addu encoding:** after reset, `instr_ready` = 1; op=0, rs=1, rt=2, rd=3 → `instr` = 32'h0022_1821 and `instr_addr` = `BASE_ADDR` one cycle later.
- **sll field forcing:** op=8, rs=7, rt=5, rd=4, shamt=2 → 32'h0005_2080 (rs forced 0). Then op=0 with shamt=9 → shamt field is 0.
- **jr / jalr with macro:**
  - With `RTYPE_ENC_JUMP_EN`: op=14, rs=31, rt=3, rd=3 → 32'h03E0_0008; op=15, rs=9, rd=31 → 32'h0120_F809.
  - Without the macro: op=14 → `err_illegal` pulse, `err_count` = 1, `instr_valid` stays 0.
- **Full and back-pressure:**
  - With `instr_ready` = 0, push 4 legal ops → `op_ready` = 0 after the 4th accept and the head stays stable.
  - Raise `instr_ready` for one cycle → one pop, `instr_addr` = `BASE_ADDR`+4, and `op_ready` = 1 the next cycle.
- **Illegal op interleave:** push op=0, op=20, op=1 back-to-back → exactly 2 words out at consecutive addresses, one `err_illegal` pulse, `err_count` = 1. After 300 illegal ops, `err_count` = 255.
- **Reset mid-operation:** with 3 words queued, assert `rst_n` = 0 asynchronously between edges → `instr_valid` = 0 and `instr_addr` = `BASE_ADDR` immediately; after release, the next word is tagged `BASE_ADDR`.
